// File: rtl/vec_op_sequencer_if.sv
// Handshake bundle between decode, the vector op sequencer and the lane datapath.
// Issue side (decode -> sequencer) and lane side (sequencer -> lanes) in one place.
interface vec_op_sequencer_if #(
  parameter int VLEN = 4
);
  localparam int IDX_W = $clog2(VLEN);

  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       opcode;
  logic [1:0]       vrd;
  logic [1:0]       vrs1;
  logic [2:0]       srs1;

  logic             lane_valid;
  logic             lane_ready;
  logic [IDX_W-1:0] lane_idx;
  logic [1:0]       lane_op;
  logic [1:0]       lane_vrd;
  logic [1:0]       lane_vrs1;
  logic [2:0]       lane_srs1;

  modport slave (
    input  issue_valid, opcode, vrd, vrs1, srs1,
    input  lane_ready,
    output issue_ready,
    output lane_valid, lane_idx, lane_op,
    output lane_vrd, lane_vrs1, lane_srs1
  );

  modport master (
    output issue_valid, opcode, vrd, vrs1, srs1,
    output lane_ready,
    input  issue_ready,
    input  lane_valid, lane_idx, lane_op,
    input  lane_vrd, lane_vrs1, lane_srs1
  );
endinterface

// File: rtl/vec_op_sequencer.sv
// Vector op sequencer: one micro-op per element, stalls front end while busy.
// VSEQ_B2B_EN: drop the DONE bubble so vector ops can issue back to back.
module vec_op_sequencer #(
  parameter int VLEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  vec_op_sequencer_if.slave bus,
  input  logic              flush,
  output logic              stall_o,
  output logic              done
);

  localparam int IDX_W = $clog2(VLEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(VLEN - 1);

`ifdef VSEQ_B2B_EN
  typedef enum logic [1:0] {IDLE, RUN} state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       vrd_q, vrd_d;
  logic [1:0]       vrs1_q, vrs1_d;
  logic [2:0]       srs1_q, srs1_d;

  logic       is_vec;
  logic [1:0] vop;
  logic       run;
  logic       hs;
  logic       last_hs;
  logic       accept;

  // Map the four vector opcodes onto the lane op code.
  always_comb begin
    is_vec = 1'b1;
    vop    = 2'b00;
    unique case (bus.opcode)
      4'b0001: vop = 2'b00;
      4'b0011: vop = 2'b01;
      4'b0101: vop = 2'b10;
      4'b1011: vop = 2'b11;
      default: is_vec = 1'b0;
    endcase
  end

  assign run     = (state_q == RUN);
  assign hs      = run & bus.lane_ready;
  assign last_hs = hs & (idx_q == LAST);
  assign accept  = bus.issue_valid & bus.issue_ready;

  assign bus.lane_valid = run;
  assign bus.lane_idx   = idx_q;
  assign bus.lane_op    = op_q;
  assign bus.lane_vrd   = vrd_q;
  assign bus.lane_vrs1  = vrs1_q;
  assign bus.lane_srs1  = srs1_q;
  assign stall_o        = (state_q != IDLE);

`ifdef VSEQ_B2B_EN
  assign bus.issue_ready = ((state_q == IDLE) | last_hs) & ~flush;
  assign done            = last_hs & ~flush;
`else
  assign bus.issue_ready = (state_q == IDLE) & ~flush;
  assign done            = (state_q == DONE) & ~flush;
`endif

  // Next state: flush wins, then element stepping, then new-op capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    vrd_d   = vrd_q;
    vrs1_d  = vrs1_q;
    srs1_d  = srs1_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept && is_vec) begin
            state_d = RUN;
            idx_d   = '0;
            op_d    = vop;
            vrd_d   = bus.vrd;
            vrs1_d  = bus.vrs1;
            srs1_d  = bus.srs1;
          end
        end
        RUN: begin
          if (last_hs) begin
            idx_d = '0;
`ifdef VSEQ_B2B_EN
            if (accept && is_vec) begin
              op_d   = vop;
              vrd_d  = bus.vrd;
              vrs1_d = bus.vrs1;
              srs1_d = bus.srs1;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = DONE;
`endif
          end else if (hs) begin
            idx_d = idx_q + 1'b1;
          end
        end
`ifndef VSEQ_B2B_EN
        DONE: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // State, index and latched operand fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      vrd_q   <= '0;
      vrs1_q  <= '0;
      srs1_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      vrd_q   <= vrd_d;
      vrs1_q  <= vrs1_d;
      srs1_q  <= srs1_d;
    end
  end

endmodule
